// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: PLL bring-up sequencer on the 50 MHz reference clock.
// It pulses the PLL reset, waits for lock with a timeout/retry budget, and
// requires lock to hold for a settle window before releasing core reset.
// It also tracks lock losses while running.
//
// Ports
//   refclk     - reference clock; all logic runs on its rising edge
//   rst_n      - asynchronous active-low reset
//   pll_locked - PLL lock indicator, asynchronous to refclk
//   req_reset  - single-cycle soft request to restart the sequence
//   pll_rst    - active-high PLL reset
//   core_rst   - active-high reset for core logic in the PLL clock domain
//   ready      - high only in RUN
//   fault      - high only in FAULT (retry budget exhausted)
//   retry_cnt  - consecutive lock timeouts, saturating at 15
//   loss_cnt   - lock losses seen in RUN, saturating at 255
//   state      - RESET=0, WAIT_LOCK=1, SETTLE=2, RUN=3, FAULT=4
module pll_reset_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 8
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       req_reset,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state
);

  localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
  // The counter never exceeds CNT_MAX-1 before the state is left.
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t          st, nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [3:0]      retry_nxt, retry_inc;
  logic [7:0]      loss_nxt;
  logic [1:0]      sync;
  logic            locked_s;

  assign locked_s  = sync[1];
  assign state     = st;
  assign retry_inc = (retry_cnt == 4'd15) ? 4'd15 : retry_cnt + 4'd1;

  always_comb begin
    nxt       = st;
    cnt_nxt   = cnt + CW'(1);
    retry_nxt = retry_cnt;
    loss_nxt  = loss_cnt;
    if (req_reset) begin
      // Re-arms the full pulse on every high cycle, so a held request
      // stretches RESET and the count starts from its last high cycle.
      nxt       = S_RESET;
      cnt_nxt   = '0;
      retry_nxt = '0;
    end else begin
      unique case (st)
        S_RESET: begin
          if (cnt == CW'(RST_CYCLES - 1)) begin
            nxt     = S_WAIT;
            cnt_nxt = '0;
          end
        end
        S_WAIT: begin
          if (locked_s) begin
            nxt     = S_SETTLE;
            cnt_nxt = '0;
          end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            retry_nxt = retry_inc;
            nxt       = (retry_inc >= 4'(MAX_RETRY)) ? S_FAULT : S_RESET;
            cnt_nxt   = '0;
          end
        end
        S_SETTLE: begin
          if (!locked_s) begin
            nxt     = S_WAIT;
            cnt_nxt = '0;
          end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            nxt       = S_RUN;
            cnt_nxt   = '0;
            retry_nxt = '0;
          end
        end
        S_RUN: begin
          cnt_nxt = '0;
          if (!locked_s) begin
            nxt      = S_RESET;
            loss_nxt = (loss_cnt == 8'hff) ? 8'hff : loss_cnt + 8'd1;
          end
        end
        S_FAULT: cnt_nxt = '0;
        default: begin
          nxt     = S_RESET;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_RESET;
      cnt       <= '0;
      sync      <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pll_rst   <= 1'b1;
      core_rst  <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      sync      <= {sync[0], pll_locked};
      st        <= nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      loss_cnt  <= loss_nxt;
      // Outputs are flops decoded from the next state, so they change on the
      // same edge as the state register and carry no input-to-output path.
      pll_rst   <= (nxt == S_RESET) || (nxt == S_FAULT);
      core_rst  <= (nxt != S_RUN);
      ready     <= (nxt == S_RUN);
      fault     <= (nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: self-checking bench for pll_reset_ctrl.
// A phase-level reference model tracks time spent in each phase and the
// two-sample lock delay; table vectors and hand sequences pin key timings.
module tb_pll_reset_ctrl;
  localparam int RC = 4, LT = 32, SC = 8, MR = 3;
  localparam int P_RESET = 0, P_WAIT = 1, P_SETTLE = 2, P_RUN = 3, P_FAULT = 4;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       req_reset = 1'b0;
  logic       pll_rst, core_rst, ready, fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int n_chk = 0, n_fail = 0;

  // model
  int      m_phase, m_elapsed, m_retry, m_loss;
  bit      m_dly[$];

  typedef struct {
    bit pl;
    int st;
    bit prst;
    bit crst;
    bit rdy;
    int retry;
  } vec_t;
  vec_t tbl[23];

  pll_reset_ctrl #(.RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .SETTLE_CYCLES(SC), .MAX_RETRY(MR)) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .req_reset(req_reset),
    .pll_rst(pll_rst), .core_rst(core_rst), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt), .state(state)
  );

  always #10 refclk = ~refclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_RESET; m_elapsed = 0; m_retry = 0; m_loss = 0;
    m_dly = '{1'b0, 1'b0};
  endtask

  task automatic go(input int p);
    m_phase = p; m_elapsed = 0;
  endtask

  // One refclk edge: the controller reacts to lock as it was two edges ago.
  task automatic model_step();
    bit ls;
    ls = m_dly.pop_front();
    m_dly.push_back(pll_locked);
    if (req_reset) begin
      m_retry = 0; go(P_RESET); return;
    end
    m_elapsed++;
    case (m_phase)
      P_RESET:  if (m_elapsed >= RC) go(P_WAIT);
      P_WAIT:
        if (ls) go(P_SETTLE);
        else if (m_elapsed >= LT) begin
          m_retry = (m_retry < 15) ? m_retry + 1 : 15;
          go((m_retry >= MR) ? P_FAULT : P_RESET);
        end
      P_SETTLE:
        if (!ls) go(P_WAIT);
        else if (m_elapsed >= SC) begin m_retry = 0; go(P_RUN); end
      P_RUN:
        if (!ls) begin
          if (m_loss < 255) m_loss++;
          go(P_RESET);
        end
      default: ;
    endcase
  endtask

  task automatic cmp_model();
    chk("m_state",    state,     m_phase);
    chk("m_pll_rst",  pll_rst,   int'(m_phase == P_RESET || m_phase == P_FAULT));
    chk("m_core_rst", core_rst,  int'(m_phase != P_RUN));
    chk("m_ready",    ready,     int'(m_phase == P_RUN));
    chk("m_fault",    fault,     int'(m_phase == P_FAULT));
    chk("m_retry",    retry_cnt, m_retry);
    chk("m_loss",     loss_cnt,  m_loss);
  endtask

  task automatic tick();
    @(posedge refclk);
    if (rst_n) model_step();
    @(negedge refclk);
    cmp_model();
  endtask

  // Leaves the bench at sample 0: just after rst_n release, before edge 1.
  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge refclk);
    rst_n = 1'b1;
    #1;
    cmp_model();
  endtask

  task automatic wait_ready(input string name, input int limit);
    int n = 0;
    while (ready !== 1'b1 && n < limit) begin tick(); n++; end
    chk(name, ready, 1);
  endtask

  initial begin
    // expected timeline of a clean bring-up, lock applied for edge 10
    for (int k = 0; k < 23; k++) begin
      tbl[k].pl    = (k >= 9);
      tbl[k].st    = (k < 4) ? 0 : (k < 12) ? 1 : (k < 20) ? 2 : 3;
      tbl[k].prst  = (k < 4);
      tbl[k].crst  = (k < 20);
      tbl[k].rdy   = (k >= 20);
      tbl[k].retry = 0;
    end

    #1;
    // ---- normal bring-up, table driven
    pll_locked = 1'b0;
    apply_reset();
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_core_rst", core_rst, 1);
    for (int k = 0; k < 23; k++) begin
      chk("tbl_state",    state,     tbl[k].st);
      chk("tbl_pll_rst",  pll_rst,   tbl[k].prst);
      chk("tbl_core_rst", core_rst,  tbl[k].crst);
      chk("tbl_ready",    ready,     tbl[k].rdy);
      chk("tbl_retry",    retry_cnt, tbl[k].retry);
      pll_locked = tbl[k].pl;
      if (k < 22) tick();
    end

    // ---- extended soft reset: RESET lasts RC cycles after the last high cycle
    req_reset = 1'b1;
    tick(); tick(); tick();
    req_reset = 1'b0;
    chk("ext_state0", state, 0);
    tick(); tick(); tick();
    chk("ext_state3", state, 0);
    tick();
    chk("ext_state4", state, 1);
    wait_ready("ext_relock", 40);

    // ---- glitch during settle, then loss in RUN and relock
    pll_locked = 1'b1;
    apply_reset();
    for (int k = 0; k <= 45; k++) begin
      if (k == 10) chk("gl_settle5", state, 2);
      if (k == 11) begin chk("gl_back_wait", state, 1); chk("gl_retry", retry_cnt, 0); end
      if (k == 19) begin chk("gl_not_ready", ready, 0); chk("gl_state19", state, 2); end
      if (k == 20) chk("gl_ready", ready, 1);
      if (k == 24) begin chk("loss_pre_rdy", ready, 1); chk("loss_pre_cnt", loss_cnt, 0); end
      if (k >= 25 && k <= 28) begin
        chk("loss_cnt", loss_cnt, 1);
        chk("loss_ready", ready, 0);
        chk("loss_core_rst", core_rst, 1);
        chk("loss_pll_rst", pll_rst, 1);
      end
      if (k == 29) chk("loss_pll_rst_off", pll_rst, 0);
      pll_locked = !(k == 8 || (k >= 22 && k <= 24));
      if (k == 38) chk("loss_relock", ready, 1);
      if (k < 45) tick();
    end
    chk("loss_cnt_kept", loss_cnt, 1);

    // ---- async reset in RUN, between edges
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_core_rst", core_rst, 1);
    chk("async_loss", loss_cnt, 0);
    chk("async_ready", ready, 0);
    chk("async_state", state, 0);
    model_reset();
    @(negedge refclk);
    rst_n = 1'b1;
    #1;
    cmp_model();

    // ---- fault path: no lock at all
    pll_locked = 1'b0;
    apply_reset();
    for (int k = 1; k <= 112; k++) begin
      tick();
      if (k == 36) begin chk("flt_retry1", retry_cnt, 1); chk("flt_st36", state, 0); end
      if (k == 72) chk("flt_retry2", retry_cnt, 2);
      if (k == 107) begin chk("flt_st107", state, 1); chk("flt_nofault", fault, 0); end
      if (k == 108 || k == 112) begin
        chk("flt_state", state, 4);
        chk("flt_fault", fault, 1);
        chk("flt_pll_rst", pll_rst, 1);
        chk("flt_retry3", retry_cnt, 3);
      end
    end

    // ---- soft recovery from FAULT
    req_reset = 1'b1;
    tick();
    req_reset = 1'b0;
    chk("rec_state", state, 0);
    chk("rec_retry", retry_cnt, 0);
    chk("rec_fault", fault, 0);
    pll_locked = 1'b1;
    wait_ready("rec_ready", 60);
    chk("rec_retry_run", retry_cnt, 0);

    // ---- randomized lock behaviour against the model
    apply_reset();
    begin
      int run = 0;
      for (int i = 0; i < 2000; i++) begin
        if (run == 0) begin
          pll_locked = ($urandom_range(0, 3) != 0);
          run = pll_locked ? $urandom_range(1, 60) : $urandom_range(1, 45);
        end
        run--;
        req_reset = ($urandom_range(0, 149) == 0);
        tick();
      end
      req_reset = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
